// File: rtl/fetch_pkg.sv
// Shared defaults and FSM state type for the instruction fetch queue.
package fetch_pkg;
  localparam int          W        = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;
endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry in-order {pc, instr} queue with flush; head is read straight from storage.
module fetch_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_pc,
  input  logic [W-1:0]  push_instr,
  input  logic          pop,
  output logic [W-1:0]  head_pc,
  output logic [W-1:0]  head_instr,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);
  logic [W-1:0]  pc_mem    [DEPTH];
  logic [W-1:0]  instr_mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? {AW{1'b0}} : p + AW'(1);
  endfunction

  // Storage, pointers and occupancy; flush discards everything but leaves storage as-is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= {W{1'b0}};
        instr_mem[i] <= {W{1'b0}};
      end
      rd_ptr <= {AW{1'b0}};
      wr_ptr <= {AW{1'b0}};
      count  <= {CW{1'b0}};
    end else if (flush) begin
      rd_ptr <= {AW{1'b0}};
      wr_ptr <= {AW{1'b0}};
      count  <= {CW{1'b0}};
    end else begin
      if (push) begin
        pc_mem[wr_ptr]    <= push_pc;
        instr_mem[wr_ptr] <= push_instr;
        wr_ptr            <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Head view and occupancy flags.
  always_comb begin
    head_pc    = pc_mem[rd_ptr];
    head_instr = instr_mem[rd_ptr];
    empty      = (count == {CW{1'b0}});
    full       = (count == CW'(DEPTH));
  end
endmodule

// File: rtl/fetch_queue_chk.sv
// Simulation-only protocol checks for the fetch queue memory side and queue credits.
module fetch_queue_chk #(
  parameter int CW = 2
) (
  input logic          clk,
  input logic          rst_n,
  input logic          rvalid,
  input logic          push,
  input logic          full,
  input logic [CW-1:0] outstanding
);
  rsp_without_req: assert property (@(posedge clk) disable iff (!rst_n)
    !(rvalid && (outstanding == {CW{1'b0}})))
    else $error("fetch_queue: i_imem_rvalid with no outstanding request");

  push_into_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full))
    else $error("fetch_queue: push into a full queue");
endmodule

// File: rtl/fetch_queue.sv
// Credit-limited instruction fetcher: issues sequential requests, queues in-order responses,
// and on redirect flushes the queue and drains responses that are still in flight.
module fetch_queue #(
  parameter int          W        = fetch_pkg::W,
  parameter logic [W-1:0] RESET_PC = W'(fetch_pkg::RESET_PC),
  parameter int          DEPTH    = fetch_pkg::DEPTH
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  output logic         o_imem_req,
  output logic [W-1:0] o_imem_addr,
  input  logic         i_imem_gnt,
  input  logic         i_imem_rvalid,
  input  logic [W-1:0] i_imem_rdata,
  input  logic         i_redirect,
  input  logic [W-1:0] i_redirect_pc,
  output logic         o_instr_valid,
  output logic [W-1:0] o_instr,
  output logic [W-1:0] o_pc,
  input  logic         i_instr_ready
);
  import fetch_pkg::fetch_state_e;
  import fetch_pkg::FETCH;
  import fetch_pkg::DRAIN;

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_e  state_q;
  logic [W-1:0]  pc_q;
  logic [W-1:0]  rsp_pc_q;
  logic [CW-1:0] outst_q;
  logic [CW-1:0] discard_q;
  logic [CW-1:0] outst_next;
  logic [CW-1:0] count;
  logic [CW:0]   credits_used;
  logic [W-1:0]  target;
  logic          grant;
  logic          rsp;
  logic          push;
  logic          pop;
  logic          empty;
  logic          full;

  // Request credits count both queued entries and responses still owed by memory.
  always_comb begin
    target       = i_redirect_pc & ~W'(32'd3);
    credits_used = {1'b0, count} + {1'b0, outst_q};
    o_imem_req   = i_rst_n && (state_q == FETCH) && !i_redirect
                   && (credits_used < (CW + 1)'(DEPTH));
    grant        = o_imem_req && i_imem_gnt;
    rsp          = i_imem_rvalid && (outst_q != {CW{1'b0}});
    push         = rsp && (state_q == FETCH) && !i_redirect;
    pop          = o_instr_valid && i_instr_ready && !i_redirect;
    outst_next   = outst_q + CW'(grant) - CW'(rsp);
  end

  assign o_imem_addr   = pc_q;
  assign o_instr_valid = !empty;

  // Fetch PC, response PC tracking, outstanding/discard counters and FETCH/DRAIN control.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      rsp_pc_q  <= RESET_PC;
      outst_q   <= {CW{1'b0}};
      discard_q <= {CW{1'b0}};
    end else begin
      outst_q <= outst_next;
      if (i_redirect) begin
        // No grant is possible this cycle, so every remaining outstanding response is stale.
        pc_q      <= target;
        rsp_pc_q  <= target;
        discard_q <= outst_next;
        state_q   <= (outst_next != {CW{1'b0}}) ? DRAIN : FETCH;
      end else begin
        if (grant) begin
          pc_q <= pc_q + W'(32'd4);
        end
        if (push) begin
          rsp_pc_q <= rsp_pc_q + W'(32'd4);
        end
        if ((state_q == DRAIN) && rsp) begin
          discard_q <= discard_q - CW'(1);
          if (discard_q == CW'(1)) begin
            state_q <= FETCH;
          end
        end
      end
    end
  end

  fetch_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk        (i_clk),
    .rst_n      (i_rst_n),
    .flush      (i_redirect),
    .push       (push),
    .push_pc    (rsp_pc_q),
    .push_instr (i_imem_rdata),
    .pop        (pop),
    .head_pc    (o_pc),
    .head_instr (o_instr),
    .count      (count),
    .empty      (empty),
    .full       (full)
  );

  fetch_queue_chk #(.CW(CW)) u_chk (
    .clk         (i_clk),
    .rst_n       (i_rst_n),
    .rvalid      (i_imem_rvalid),
    .push        (push),
    .full        (full),
    .outstanding (outst_q)
  );
endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a small in-order memory model plus an expected-entry queue.
module tb_fetch_queue;
  localparam int W     = 32;
  localparam int DEPTH = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         imem_req;
  logic [W-1:0] imem_addr;
  logic         gnt;
  logic         rvalid;
  logic [W-1:0] rdata;
  logic         redirect;
  logic [W-1:0] redirect_pc;
  logic         instr_valid;
  logic [W-1:0] instr;
  logic [W-1:0] pc;
  logic         ready;
  logic         req2;
  logic [W-1:0] addr2;
  logic         valid2;
  logic [W-1:0] instr2;
  logic [W-1:0] pc2;

  always #5 clk = ~clk;

  fetch_queue #(.W(W), .RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .o_imem_req(imem_req), .o_imem_addr(imem_addr),
    .i_imem_gnt(gnt), .i_imem_rvalid(rvalid), .i_imem_rdata(rdata),
    .i_redirect(redirect), .i_redirect_pc(redirect_pc), .o_instr_valid(instr_valid),
    .o_instr(instr), .o_pc(pc), .i_instr_ready(ready)
  );

  fetch_queue #(.W(W), .RESET_PC(32'hFFFF_FFFC), .DEPTH(DEPTH)) dut_wrap (
    .i_clk(clk), .i_rst_n(rst_n), .o_imem_req(req2), .o_imem_addr(addr2),
    .i_imem_gnt(1'b1), .i_imem_rvalid(1'b0), .i_imem_rdata(32'h0000_0000),
    .i_redirect(1'b0), .i_redirect_pc(32'h0000_0000), .o_instr_valid(valid2),
    .o_instr(instr2), .o_pc(pc2), .i_instr_ready(1'b1)
  );

  typedef struct {
    logic [W-1:0] addr;
    int           epoch;
    int           due;
  } req_t;

  typedef struct {
    logic [W-1:0] pc;
    logic [W-1:0] instr;
  } ent_t;

  req_t         pend[$];
  ent_t         sb[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           epoch = 0;
  int           max_lat = 0;
  bit           fixed_data = 1'b1;
  bit           rsp_en = 1'b1;
  logic [W-1:0] exp_addr = 32'h0000_0000;

  function automatic logic [W-1:0] instr_of(input logic [W-1:0] a);
    return fixed_data ? 32'h0000_0013 : ((a ^ 32'h1357_9BDF) + 32'd7);
  endfunction

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle, entered at a falling edge: drive memory, check outputs, update the model.
  task automatic cycle();
    logic do_rsp;
    logic do_grant;
    req_t r;
    ent_t e;
    do_rsp = rsp_en && (pend.size() > 0) && (pend[0].due <= cyc);
    rvalid = do_rsp;
    rdata  = do_rsp ? instr_of(pend[0].addr) : 32'hDEAD_BEEF;
    #1;
    check_val("valid", instr_valid, sb.size() != 0);
    if (instr_valid && sb.size() > 0) begin
      check_val("head_pc", pc, sb[0].pc);
      check_val("head_instr", instr, sb[0].instr);
    end
    check_val("credits", (pend.size() + sb.size()) <= DEPTH, 1'b1);
    if (redirect) check_val("req_on_redirect", imem_req, 1'b0);
    if (imem_req) check_val("req_addr", imem_addr, exp_addr);
    if (instr_valid && ready && !redirect && sb.size() > 0) void'(sb.pop_front());
    if (do_rsp) begin
      r = pend.pop_front();
      if (r.epoch == epoch && !redirect) begin
        e.pc    = r.addr;
        e.instr = instr_of(r.addr);
        sb.push_back(e);
      end
    end
    do_grant = imem_req && gnt;
    if (do_grant) begin
      r.addr  = imem_addr;
      r.epoch = epoch;
      r.due   = cyc + 1 + int'($urandom_range(max_lat, 0));
      pend.push_back(r);
      exp_addr = exp_addr + 32'd4;
    end
    if (redirect) begin
      epoch++;
      sb.delete();
      exp_addr = redirect_pc & 32'hFFFF_FFFC;
    end
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; gnt = 1'b1; rvalid = 1'b0; rdata = 32'h0000_0000;
    redirect = 1'b0; redirect_pc = 32'h0000_0000; ready = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_req", imem_req, 1'b0);
    check_val("rst_valid", instr_valid, 1'b0);
    check_val("rst_instr", instr, 32'h0000_0000);
    check_val("rst_pc", pc, 32'h0000_0000);
    check_val("rst_wrap_req", req2, 1'b0);
    check_val("rst_wrap_valid", valid2, 1'b0);
    check_val("rst_wrap_out", instr2 | pc2, 32'h0000_0000);

    // Basic stream of 0x00000013 and the wrapping reset PC on the second instance.
    rst_n = 1'b1;
    #1;
    check_val("first_req", imem_req, 1'b1);
    check_val("wrap_first_addr", addr2, 32'hFFFF_FFFC);
    check_val("wrap_first_req", req2, 1'b1);
    cycle();
    #1;
    check_val("wrap_second_addr", addr2, 32'h0000_0000);
    check_val("wrap_second_req", req2, 1'b1);
    repeat (6) cycle();

    // Backpressure: decode stalls for ten cycles, then resumes.
    fixed_data = 1'b0;
    ready = 1'b0;
    repeat (10) cycle();
    ready = 1'b1;
    repeat (4) cycle();

    // Redirect to 0x100 with two responses held back by memory.
    rsp_en = 1'b0;
    repeat (4) cycle();
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    cycle();
    redirect = 1'b0; rsp_en = 1'b1;
    repeat (8) cycle();

    // Redirect in a busy cycle (response and pop together), unaligned target.
    repeat (4) cycle();
    redirect = 1'b1; redirect_pc = 32'h0000_0203;
    cycle();
    redirect = 1'b0;
    repeat (8) cycle();

    // Random traffic with variable latency and occasional redirects.
    max_lat = 2;
    for (int i = 0; i < 400; i++) begin
      gnt         = 1'($urandom_range(1, 0));
      ready       = 1'($urandom_range(3, 0) != 0);
      rsp_en      = 1'($urandom_range(3, 0) != 0);
      redirect    = ($urandom_range(15, 0) == 0);
      redirect_pc = $urandom;
      cycle();
    end
    gnt = 1'b1; ready = 1'b1; rsp_en = 1'b1; redirect = 1'b0; max_lat = 0;
    repeat (6) cycle();

    // Mid-stream reset with the queue full.
    ready = 1'b0;
    repeat (6) cycle();
    check_val("queue_full_before_reset", instr_valid, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    check_val("midrst_valid", instr_valid, 1'b0);
    check_val("midrst_req", imem_req, 1'b0);
    check_val("midrst_instr", instr, 32'h0000_0000);
    pend.delete();
    sb.delete();
    epoch++;
    exp_addr = 32'h0000_0000;
    rvalid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ready = 1'b1;
    #1;
    check_val("post_rst_req", imem_req, 1'b1);
    check_val("post_rst_addr", imem_addr, 32'h0000_0000);
    repeat (8) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
